// File: rtl/mod20_bcd_display.sv
// Mod-20 count display: serial double-dabble binary-to-BCD conversion driving a
// two-digit multiplexed common-anode seven-segment display.
module mod20_bcd_display #(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter int unsigned MAX_COUNT     = 20,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [4:0] count_in,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       busy,
  output logic       valid,
  output logic       out_of_range,
  output logic [1:0] an,
  output logic [6:0] seg
);

  localparam int unsigned CW         = 5;
  localparam int unsigned SW         = CW + 8;
  localparam int unsigned PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [2:0]    LAST_ITER  = 3'(CW - 1);
  localparam logic [6:0]    SEG_OFF    = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_sample_q;
  logic [CW-1:0] r_conv_src;
  logic          r_pending;
  logic [SW-1:0] r_shift;
  logic [2:0]    r_iter;
  logic [PW-1:0] r_presc;
  logic          r_digit_sel;

  logic [SW-1:0] w_adj;
  logic [1:0]    w_an;
  logic [6:0]    w_seg;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = SEG_OFF;
    endcase
  endfunction

  // Add-3 correction applied to each BCD nibble before the shift
  always_comb begin
    w_adj = r_shift;
    if (r_shift[8:5] >= 4'd5)
      w_adj[8:5] = r_shift[8:5] + 4'd3;
    if (r_shift[12:9] >= 4'd5)
      w_adj[12:9] = r_shift[12:9] + 4'd3;
  end

  // Input capture and converter FSM; only DONE ever updates the digits
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_sample_q   <= '0;
      r_conv_src   <= '0;
      r_pending    <= 1'b1;
      r_shift      <= '0;
      r_iter       <= '0;
      bcd_tens     <= '0;
      bcd_ones     <= '0;
      busy         <= 1'b0;
      valid        <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      r_sample_q <= count_in;
      case (r_state)
        S_IDLE: begin
          if (r_pending || (r_sample_q != r_conv_src)) begin
            r_conv_src <= r_sample_q;
            r_shift    <= {8'b0, r_sample_q};
            r_iter     <= '0;
            busy       <= 1'b1;
            r_pending  <= 1'b0;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_shift <= SW'({w_adj, 1'b0});
          r_iter  <= r_iter + 3'd1;
          if (r_iter == LAST_ITER)
            r_state <= S_DONE;
        end
        S_DONE: begin
          bcd_tens     <= r_shift[12:9];
          bcd_ones     <= r_shift[8:5];
          out_of_range <= (32'(r_conv_src) > MAX_COUNT);
          valid        <= 1'b1;
          busy         <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Digit selection with leading-zero blanking; dark until first result
  always_comb begin
    w_an  = 2'b11;
    w_seg = SEG_OFF;
    if (valid) begin
      if (!r_digit_sel) begin
        w_an  = 2'b10;
        w_seg = seg_decode(bcd_ones);
      end else if (!(BLANK_LEADING && (bcd_tens == 4'd0))) begin
        w_an  = 2'b01;
        w_seg = seg_decode(bcd_tens);
      end
    end
  end

  // Scan prescaler and registered display drive
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_presc     <= '0;
      r_digit_sel <= 1'b0;
      an          <= 2'b11;
      seg         <= SEG_OFF;
    end else begin
      if (r_presc == PRESC_LAST) begin
        r_presc     <= '0;
        r_digit_sel <= ~r_digit_sel;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      an  <= w_an;
      seg <= w_seg;
    end
  end

endmodule

// File: tb/tb_mod20_bcd_display.sv
// Bench for mod20_bcd_display: scoreboarded conversions, latency, scan and
// asynchronous-reset checks.
module tb_mod20_bcd_display;

  logic       clk;
  logic       Reset;
  logic [4:0] count_in;
  logic [3:0] bcd_tens, bcd_ones;
  logic       busy, valid, out_of_range;
  logic [1:0] an;
  logic [6:0] seg;

  logic [3:0] bcd_tens_b, bcd_ones_b;
  logic       busy_b, valid_b, out_of_range_b;
  logic [1:0] an_b;
  logic [6:0] seg_b;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       oor;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_busy = 1'b0;

  mod20_bcd_display #(.REFRESH_DIV(4), .MAX_COUNT(20), .BLANK_LEADING(1'b1)) u_dut (
    .clk(clk), .Reset(Reset), .count_in(count_in),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .busy(busy), .valid(valid),
    .out_of_range(out_of_range), .an(an), .seg(seg)
  );

  mod20_bcd_display #(.REFRESH_DIV(4), .MAX_COUNT(20), .BLANK_LEADING(1'b0)) u_dut_nb (
    .clk(clk), .Reset(Reset), .count_in(count_in),
    .bcd_tens(bcd_tens_b), .bcd_ones(bcd_ones_b), .busy(busy_b), .valid(valid_b),
    .out_of_range(out_of_range_b), .an(an_b), .seg(seg_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int v);
    exp_t e;
    e.tens = 4'(v / 10);
    e.ones = 4'(v % 10);
    e.oor  = (v > 20);
    return e;
  endfunction

  // Scoreboard: every falling busy outside reset must match the queue head
  always @(posedge clk) begin
    #1;
    if (!Reset && prev_busy && !busy) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_tens", bcd_tens, mon_e.tens);
        check("sb_ones", bcd_ones, mon_e.ones);
        check("sb_oor", out_of_range, mon_e.oor);
      end
    end
    prev_busy = busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Called just after the load edge; checks busy span and results at E7
  task automatic finish_conv(input string tag, input int v);
    exp_t e;
    e = mk(v);
    #1 check({tag, "_busy_e1"}, busy, 1);
    repeat (5) @(posedge clk);
    #1 check({tag, "_busy_e6"}, busy, 1);
    @(posedge clk);
    #1;
    check({tag, "_busy_e7"}, busy, 0);
    check({tag, "_valid"}, valid, 1);
    check({tag, "_tens"}, bcd_tens, e.tens);
    check({tag, "_ones"}, bcd_ones, e.ones);
    check({tag, "_oor"}, out_of_range, e.oor);
    repeat (2) @(posedge clk);
  endtask

  task automatic convert(input string tag, input int v);
    @(negedge clk);
    count_in = 5'(v);
    sb.push_back(mk(v));
    @(posedge clk);
    @(posedge clk);
    finish_conv(tag, v);
  endtask

  // 16 cycles with REFRESH_DIV=4 gives exactly 8 samples of each slot
  task automatic scan(input bit use_b, input string tag,
                      input logic [1:0] an0, input logic [6:0] seg0,
                      input logic [1:0] an1, input logic [6:0] seg1);
    int h0 = 0;
    int h1 = 0;
    int bad = 0;
    logic [1:0] a;
    logic [6:0] s;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a = use_b ? an_b : an;
      s = use_b ? seg_b : seg;
      if (a == an0 && s == seg0) h0++;
      else if (a == an1 && s == seg1) h1++;
      else bad++;
    end
    check({tag, "_bad"}, 32'(bad), 0);
    check({tag, "_ones_slot"}, 32'(h0), 8);
    check({tag, "_tens_slot"}, 32'(h1), 8);
  endtask

  initial begin
    int busy_cnt;
    Reset    = 1'b0;
    count_in = 5'd0;
    #1 Reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_oor", out_of_range, 0);
    check("rst_tens", bcd_tens, 0);
    check("rst_ones", bcd_ones, 0);
    check("rst_an", an, 2'b11);
    check("rst_seg", seg, 7'h7F);
    repeat (2) @(posedge clk);

    // Release with count 0: pending forces a first conversion
    @(negedge clk);
    Reset = 1'b0;
    sb.push_back(mk(0));
    @(posedge clk);
    finish_conv("init0", 0);
    scan(1'b0, "scan0", 2'b10, 7'h40, 2'b11, 7'h7F);

    convert("c20", 20);
    scan(1'b0, "scan20", 2'b10, 7'h40, 2'b01, 7'h24);
    convert("c19", 19);
    scan(1'b0, "scan19", 2'b10, 7'h10, 2'b01, 7'h79);
    convert("c1", 1);
    scan(1'b0, "scan1", 2'b10, 7'h79, 2'b11, 7'h7F);
    scan(1'b1, "scan1_nb", 2'b10, 7'h79, 2'b01, 7'h40);
    convert("c25", 25);
    convert("c20b", 20);

    // Unchanged input: no conversion starts
    @(negedge clk);
    count_in = 5'd20;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("idle_busy_cycles", 32'(busy_cnt), 0);
    check("idle_tens", bcd_tens, 2);

    // 7 sampled at E0, 13 at E3: 07 at E7, reload at E8, 13 at E14
    @(negedge clk);
    count_in = 5'd7;
    sb.push_back(mk(7));
    @(posedge clk);
    @(posedge clk);
    #1 check("chg_busy_e1", busy, 1);
    @(posedge clk);
    @(negedge clk);
    count_in = 5'd13;
    sb.push_back(mk(13));
    repeat (5) @(posedge clk);
    #1;
    check("chg_busy_e7", busy, 0);
    check("chg_tens_e7", bcd_tens, 0);
    check("chg_ones_e7", bcd_ones, 7);
    @(posedge clk);
    #1;
    check("chg_busy_e8", busy, 1);
    check("chg_ones_e8", bcd_ones, 7);
    repeat (5) @(posedge clk);
    #1;
    check("chg_ones_e13", bcd_ones, 7);
    @(posedge clk);
    #1;
    check("chg_busy_e14", busy, 0);
    check("chg_tens_e14", bcd_tens, 1);
    check("chg_ones_e14", bcd_ones, 3);
    repeat (2) @(posedge clk);

    convert("c28", 28);

    // Asynchronous reset between edges while shifting the value 9
    @(negedge clk);
    count_in = 5'd9;
    repeat (3) @(posedge clk);
    #2 Reset = 1'b1;
    #1;
    check("ar_busy", busy, 0);
    check("ar_valid", valid, 0);
    check("ar_oor", out_of_range, 0);
    check("ar_tens", bcd_tens, 0);
    check("ar_ones", bcd_ones, 0);
    check("ar_an", an, 2'b11);
    check("ar_seg", seg, 7'h7F);
    repeat (2) @(posedge clk);
    // Pending load uses the reset sample (0), then the held 9 follows
    @(negedge clk);
    Reset = 1'b0;
    sb.push_back(mk(0));
    sb.push_back(mk(9));
    repeat (24) @(posedge clk);
    #1;
    check("ar_rerun_valid", valid, 1);
    check("ar_rerun_tens", bcd_tens, 0);
    check("ar_rerun_ones", bcd_ones, 9);
    check("ar_rerun_busy", busy, 0);
    check("sb_drain", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mod20_bcd_display.md
Name: mod20_bcd_display

Overview:
- Downstream consumer of the 5-bit mod-20 up/down counter value.
- Converts the count to two BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives a two-digit multiplexed common-anode seven-segment display, with leading-zero blanking and an out-of-range flag.
- Runs on posedge clk. The counter updates on negedge, so count_in is stable at every posedge sample.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit scan slot; must be >= 1.
- MAX_COUNT, 20: largest legal count; values above it set out_of_range.
- BLANK_LEADING, 1: 1 = tens digit is dark when tens is 0.

Ports:
- clk  in  1  system clock, posedge active
- Reset  in  1  reset, asynchronous, active-high
- count_in  in  5  binary count from the counter stage, 0..31
- bcd_tens  out  4  converted tens digit, 0..3
- bcd_ones  out  4  converted ones digit, 0..9
- busy  out  1  conversion in progress
- valid  out  1  at least one conversion completed since reset
- out_of_range  out  1  last converted value > MAX_COUNT
- an  out  2  active-low digit enables; an[0] = ones, an[1] = tens
- seg  out  7  active-low segments; seg[0] = a ... seg[6] = g

Behaviour:
- Reset (asynchronous, takes effect without a clock edge):
  - sample_q = 0, conv_src = 0, pending = 1, FSM = IDLE.
  - bcd_tens = bcd_ones = 0; busy = valid = out_of_range = 0.
  - Prescaler = 0, digit_sel = 0, an = 2'b11, seg = 7'h7F.
  - Reset mid-conversion aborts it; no partial result is ever output.
- Input capture: sample_q <= count_in on every posedge (edge E0).
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE: if pending = 1 or sample_q != conv_src, then on the next edge (E1):
    - conv_src <= sample_q; shift register loaded ({8'b0, sample_q}).
    - iteration counter = 0; busy = 1; pending cleared; go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT: each edge, first add 3 to any BCD nibble >= 5, then shift the whole register left 1.
    - 5 iterations on edges E2..E6.
    - The edge with iteration counter = 4 moves to DONE.
  - DONE (edge E7):
    - bcd_tens/bcd_ones <= result nibbles.
    - out_of_range <= (conv_src > MAX_COUNT); valid <= 1; busy <= 0.
    - Go to IDLE.
  - Latency: outputs update exactly 7 edges after the sampling edge E0.
  - Input changes while busy: the conversion in progress completes with its snapshot; no abort. The new value is detected in the next IDLE cycle, so the earliest reload is the edge after DONE.
  - Unchanged input: no conversion; busy stays 0.
- Arithmetic: input 0..31 maps exactly to tens 0..3 and ones 0..9. Values 21..31 still convert correctly; only out_of_range flags them. Digits shown are the converted value.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1; at the terminal count it wraps to 0 and toggles digit_sel.
  - REFRESH_DIV = 1 toggles digit_sel every cycle.
  - digit_sel = 0: an = 2'b10, seg = decode(bcd_ones).
  - digit_sel = 1: an = 2'b01, seg = decode(bcd_tens).
  - Exception: if BLANK_LEADING = 1 and bcd_tens = 0, then an = 2'b11, seg = 7'h7F.
  - While valid = 0: an = 2'b11, seg = 7'h7F regardless of digit_sel; the prescaler still runs.
  - an and seg are registered and change one edge after digit_sel or digit changes.
- Decode (active-low, g..a):
  - 0 = 0x40, 1 = 0x79, 2 = 0x24, 3 = 0x30, 4 = 0x19
  - 5 = 0x12, 6 = 0x02, 7 = 0x78, 8 = 0x00, 9 = 0x10
  - Other codes = 0x7F.

Test Plan:
- Bench uses REFRESH_DIV = 4.
- Release Reset with count_in = 0:
  - busy = 1 after E1.
  - At E7: valid = 1, busy = 0, tens = 0, ones = 0.
  - Ones slot: an = 10, seg = 0x40. Tens slot: an = 11, seg = 0x7F.
- count_in 0 -> 20:
  - 7 edges after the sample: tens = 2, ones = 0, out_of_range = 0.
  - Display alternates every 4 cycles between an = 10/seg = 0x40 and an = 01/seg = 0x24.
- count_in = 19, then 1 (wrap):
  - 19: tens = 1, ones = 9, seg 0x79 / 0x10.
  - 1: tens = 0 (slot blanked), ones = 1, seg = 0x79.
  - With BLANK_LEADING = 0, count_in = 1: tens slot shows an = 01, seg = 0x40.
- count_in = 25, MAX_COUNT = 20: tens = 2, ones = 5, out_of_range = 1. Then count_in = 20: out_of_range returns to 0.
- Change while busy: count_in = 7 sampled at E0, then 13 at E3.
  - Outputs show 07 at E7.
  - busy rises again at E8; outputs show 13 at E14. No intermediate value appears.
- Assert Reset asynchronously mid-SHIFT (between edges): busy, valid, out_of_range and digits go to 0, an = 11, seg = 0x7F, with no clock edge. After release, the conversion reruns (pending = 1).
